// File: rtl/img_line_packer_if.sv
// img_line_packer_if: read-FIFO side and UDP-transmitter side signals of the line packer.
interface img_line_packer_if;
    logic        frame_start;
    logic        pix_ready;
    logic [15:0] pix_data;
    logic        pix_rd_en;
    logic        rd_vsync;
    logic        eth_tx_req;
    logic        eth_tx_done;
    logic        eth_tx_start;
    logic [31:0] eth_tx_data;
    logic [15:0] eth_tx_data_num;
    logic        busy;
    logic        pkt_err;
    modport master (
        input  frame_start, pix_ready, pix_data, eth_tx_req, eth_tx_done,
        output pix_rd_en, rd_vsync, eth_tx_start, eth_tx_data, eth_tx_data_num, busy, pkt_err
    );
    modport slave (
        output frame_start, pix_ready, pix_data, eth_tx_req, eth_tx_done,
        input  pix_rd_en, rd_vsync, eth_tx_start, eth_tx_data, eth_tx_data_num, busy, pkt_err
    );
endinterface

// File: rtl/img_line_packer.sv
// img_line_packer: packs one image line per UDP payload (8-byte header + RGB565 pixels).
module img_line_packer #(
    parameter int          H_PIXEL = 640,
    parameter int          V_PIXEL = 480,
    parameter logic [15:0] GAP_CYC = 16'd64,
    parameter logic [15:0] MAGIC   = 16'hA55A
) (
    input logic               sys_clk,
    input logic               sys_rst_n,
    img_line_packer_if.master bus
);
    localparam logic [15:0] W_LAST = 16'(H_PIXEL / 2 + 1);
    localparam logic [15:0] H_W    = 16'(H_PIXEL);
    localparam logic [15:0] V_W    = 16'(V_PIXEL);

    typedef enum logic [3:0] {IDLE, WAIT_FR, WAIT_LN, PREF, START, SEND, WAIT_DN, DRAIN, GAP} state_t;

    state_t      r_state, w_next;
    logic [15:0] r_line, r_frame, r_word, r_rd_cnt, r_gap;
    logic [31:0] r_buf, r_tx_data, w_word;
    logic [1:0]  r_pf;
    logic        r_rd_d, r_lo, r_vsync, r_err;
    logic        w_rd_en, w_req_send, w_early, w_gap_end, w_pf_start;

    // r_pf counts down the two back-to-back reads of a pixel pair; DRAIN reads until the line is consumed
    assign w_rd_en    = (r_state == DRAIN) ? (r_rd_cnt != H_W) : (r_pf != 2'd0);
    assign w_early    = r_state == SEND && bus.eth_tx_done;
    assign w_req_send = r_state == SEND && bus.eth_tx_req && !bus.eth_tx_done;
    assign w_gap_end  = r_state == GAP && r_gap == GAP_CYC - 16'd1;
    assign w_pf_start = (r_state == WAIT_LN && bus.pix_ready) ||
                        (w_req_send && r_word >= 16'd2 && r_word != W_LAST);
    assign w_word     = (r_word == 16'd0) ? {MAGIC, r_line} :
                        (r_word == 16'd1) ? {r_frame, H_W} : r_buf;

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = WAIT_FR;
            WAIT_FR: w_next = bus.frame_start ? WAIT_LN : WAIT_FR;
            WAIT_LN: w_next = bus.pix_ready ? PREF : WAIT_LN;
            PREF:    w_next = (r_pf == 2'd1) ? START : PREF;
            START:   w_next = SEND;
            SEND:    w_next = w_early ? DRAIN : (w_req_send && r_word == W_LAST) ? WAIT_DN : SEND;
            WAIT_DN: w_next = bus.eth_tx_done ? GAP : WAIT_DN;
            DRAIN:   w_next = (r_rd_cnt == H_W) ? GAP : DRAIN;
            GAP:     w_next = !w_gap_end ? GAP : (r_line == V_W) ? WAIT_FR : WAIT_LN;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_state   <= IDLE;
            r_line    <= '0;
            r_frame   <= '0;
            r_word    <= '0;
            r_rd_cnt  <= '0;
            r_gap     <= '0;
            r_buf     <= '0;
            r_tx_data <= '0;
            r_pf      <= '0;
            r_rd_d    <= 1'b0;
            r_lo      <= 1'b0;
            r_vsync   <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_state  <= w_next;
            r_vsync  <= r_state == WAIT_FR && bus.frame_start;
            r_pf     <= w_pf_start ? 2'd2 : (r_pf != 2'd0) ? r_pf - 2'd1 : 2'd0;
            r_rd_cnt <= (r_state == WAIT_LN) ? 16'd0 : r_rd_cnt + 16'(w_rd_en);
            r_rd_d   <= w_rd_en && r_state != DRAIN;
            r_lo     <= (r_state == WAIT_LN) ? 1'b0 : r_rd_d ? ~r_lo : r_lo;
            r_word   <= (r_state == START) ? 16'd0 : w_req_send ? r_word + 16'd1 : r_word;
            r_gap    <= (r_state == GAP) ? r_gap + 16'd1 : 16'd0;
            r_err    <= r_err | w_early | (bus.eth_tx_req && r_state != SEND);
            r_line   <= (r_state == WAIT_FR && bus.frame_start) ? 16'd0 :
                        ((r_state == WAIT_DN && bus.eth_tx_done) || w_early) ? r_line + 16'd1 : r_line;
            r_frame  <= (w_gap_end && r_line == V_W) ? r_frame + 16'd1 : r_frame;
            if (r_rd_d && !r_lo)
                r_buf[31:16] <= bus.pix_data;
            if (r_rd_d && r_lo)
                r_buf[15:0] <= bus.pix_data;
            if (w_req_send)
                r_tx_data <= w_word;
            else if (bus.eth_tx_req && r_state != SEND)
                r_tx_data <= '0;
        end
    end

    assign bus.pix_rd_en       = w_rd_en;
    assign bus.rd_vsync        = r_vsync;
    assign bus.eth_tx_start    = r_state == START;
    assign bus.eth_tx_data     = r_tx_data;
    assign bus.eth_tx_data_num = 16'(8 + 2 * H_PIXEL);
    assign bus.busy            = r_state != IDLE;
    assign bus.pkt_err         = r_err;
endmodule
